prbs9_checker: RTL

- Downstream consumer of the prbs9 generator's serial output (o_bit). Typically sits after a loopback or channel path.
- Self-synchronises to the PRBS9 sequence x^9+x^5+1, with no seed knowledge required.
- Once locked, compares every received bit against a free-running local reference and reports per-bit errors, bits-checked and errors-counted (BER numerator and denominator).
- Optionally declares loss of lock when errors are too dense.

---
 rtl/prbs9_pkg.sv | 18 +
 rtl/prbs9_lol_monitor.sv | 61 ++++++
 rtl/prbs9_checker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/prbs9_pkg.sv
// Shared PRBS9 (x^9 + x^5 + 1) definitions used by the checker and the generator.
package prbs9_pkg;

    localparam int PRBS9_ORDER  = 9;
    localparam int PRBS9_TAP_HI = 8;
    localparam int PRBS9_TAP_LO = 4;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs9_state_t;

    // hist[0] is the newest bit; the result is the bit that should follow hist.
    function automatic logic prbs9_next_bit(input logic [PRBS9_ORDER-1:0] hist);
        return hist[PRBS9_TAP_HI] ^ hist[PRBS9_TAP_LO];
    endfunction

endpackage

// File: rtl/prbs9_lol_monitor.sv
// Loss-of-lock window monitor: counts checked bits and mismatches per window and
// flags when the mismatch count reaches the threshold. Used under PRBS9_CHK_LOL_EN.
module prbs9_lol_monitor
    import prbs9_pkg::*;
#(
    parameter int LOSS_WINDOW = 128,
    parameter int LOSS_THRESH = 8
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_active,
    input  logic i_mismatch,
    input  logic i_clear,
    output logic o_loss
);

    localparam int WIN_W = $clog2(LOSS_WINDOW + 1);
    localparam int ERR_W = $clog2(LOSS_THRESH + 1);

    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(LOSS_WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_ONE   = WIN_W'(1);
    localparam logic [ERR_W-1:0] ERR_LAST  = ERR_W'(LOSS_THRESH - 1);
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [ERR_W-1:0] win_err_q, win_err_d;

    // The error counter never rests at the threshold, so reaching it is a single compare.
    assign o_loss = i_active && i_mismatch && (win_err_q == ERR_LAST);

    always_comb begin
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        if (i_active) begin
            if (o_loss || (win_cnt_q == WIN_LAST)) begin
                win_cnt_d = '0;
                win_err_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + WIN_ONE;
                if (i_mismatch) begin
                    win_err_d = win_err_q + ERR_ONE;
                end
            end
        end
        if (i_clear) begin
            win_cnt_d = '0;
            win_err_d = '0;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
        end
    end

endmodule

// File: rtl/prbs9_checker.sv
// Self-synchronising PRBS9 checker with saturating bit/error counters.
// Define PRBS9_CHK_LOL_EN to add loss-of-lock on dense errors.
module prbs9_checker
    import prbs9_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int CNT_W      = 32
`ifdef PRBS9_CHK_LOL_EN
    ,
    parameter int LOSS_WINDOW = 128,
    parameter int LOSS_THRESH = 8
`endif
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_lock,
    output logic             o_error,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count,
    output prbs9_state_t     o_dbg_state
);

    localparam logic [3:0]       FILL_FULL = 4'(PRBS9_ORDER);
    localparam logic [3:0]       FILL_ONE  = 4'd1;
    localparam logic [7:0]       LOCK_CNT  = 8'(LOCK_COUNT);
    localparam logic [7:0]       MATCH_ONE = 8'd1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    prbs9_state_t              state_q, state_d;
    logic [PRBS9_ORDER-1:0]    hist_q, hist_d;
    logic [3:0]                fill_q, fill_d;
    logic [7:0]                match_cnt_q, match_cnt_d;
    logic                      lock_q, lock_d;
    logic                      error_q, error_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]          err_cnt_q, err_cnt_d;

    logic pred;
    logic mismatch;
    logic locked_bit;
    logic loss;

    assign pred       = prbs9_next_bit(hist_q);
    assign mismatch   = (i_bit != pred);
    assign locked_bit = i_enable && (state_q == LOCKED);

`ifdef PRBS9_CHK_LOL_EN
    prbs9_lol_monitor #(
        .LOSS_WINDOW (LOSS_WINDOW),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_lol_monitor (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_active   (locked_bit),
        .i_mismatch (mismatch),
        .i_clear    (i_clear),
        .o_loss     (loss)
    );
`else
    assign loss = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_cnt_d = match_cnt_q;
        error_d     = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (i_enable) begin
            case (state_q)
                SEARCH: begin
                    hist_d = {hist_q[PRBS9_ORDER-2:0], i_bit};
                    if (fill_q < FILL_FULL) begin
                        fill_d = fill_q + FILL_ONE;
                    end else if (!mismatch && (hist_q != '0)) begin
                        match_cnt_d = match_cnt_q + MATCH_ONE;
                        if (match_cnt_d == LOCK_CNT) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-running reference: a channel error cannot corrupt the history.
                    hist_d = {hist_q[PRBS9_ORDER-2:0], pred};
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                    if (mismatch) begin
                        error_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_ONE;
                        end
                    end
                    if (loss) begin
                        state_d     = SEARCH;
                        fill_d      = '0;
                        match_cnt_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (i_clear) begin
            error_d   = 1'b0;
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end

        lock_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            match_cnt_q <= '0;
            lock_q      <= 1'b0;
            error_q     <= 1'b0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_cnt_q <= match_cnt_d;
            lock_q      <= lock_d;
            error_q     <= error_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_lock      = lock_q;
    assign o_error     = error_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;
    assign o_dbg_state = state_q;

endmodule
